seq_add_sub: RTL and testbench

SEQ_ADD_SUB -- requirements
Module: seq_add_sub

---
 rtl/seq_add_sub.sv | 75 +++++++
 tb/tb_seq_add_sub.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_add_sub.sv
// seq_add_sub: multi-cycle chunked adder/subtractor with registered result and ALU flags
module seq_add_sub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_r, b_r, sum_r, sum_nx;
  logic [CHUNK:0] csum;
  logic [CW-1:0] cnt;
  logic carry, accept, last, msb_cin;
  always_comb begin
    accept = start && state != BUSY;
    last = cnt == CW'(NCHUNK - 1);
    csum = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    sum_nx = (sum_r >> CHUNK) | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));
    msb_cin = a_r[CHUNK-1] ^ b_r[CHUNK-1] ^ csum[CHUNK-1];
    state_nx = accept ? BUSY : state == BUSY ? (last ? DONE : BUSY) : IDLE;
  end
  assign busy = state == BUSY;
  assign done = state == DONE;
  // operands shift right so the active chunk is always at bit 0; sum fills from the top
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      sum_r <= '0;
      carry <= 1'b0;
      cnt <= '0;
      result <= '0;
      c_out <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b1;
      negative <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_r <= a;
        b_r <= op ? ~b : b;
        carry <= op;
        cnt <= '0;
      end else if (state == BUSY) begin
        a_r <= a_r >> CHUNK;
        b_r <= b_r >> CHUNK;
        sum_r <= sum_nx;
        carry <= csum[CHUNK];
        cnt <= cnt + 1'b1;
        if (last) begin
          result <= sum_nx;
          c_out <= csum[CHUNK];
          overflow <= msb_cin ^ csum[CHUNK];
          zero <= sum_nx == '0;
          negative <= sum_nx[WIDTH-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_add_sub.sv
// tb_seq_add_sub: randomized and directed checks of three seq_add_sub configurations against an arithmetic model
module tb_seq_add_sub;
  logic clock, clear, start, op;
  logic [31:0] a, b;
  logic [31:0] res[3];
  logic busy_v[3], done_v[3], c_v[3], ov_v[3], z_v[3], n_v[3];
  int wd[3] = '{32, 16, 16};
  int nch[3] = '{4, 4, 1};
  int checks = 0, errors = 0;
  int lat[3];
  logic [35:0] got[3];
  bit early[3], busy0[3], both;

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int WG = g == 0 ? 32 : 16;
    localparam int CG = g == 0 ? 8 : g == 1 ? 4 : 16;
    logic [WG-1:0] r;
    seq_add_sub #(.WIDTH(WG), .CHUNK(CG)) u_dut (
      .clock(clock), .clear(clear), .start(start), .op(op),
      .a(a[WG-1:0]), .b(b[WG-1:0]),
      .busy(busy_v[g]), .done(done_v[g]), .result(r),
      .c_out(c_v[g]), .overflow(ov_v[g]), .zero(z_v[g]), .negative(n_v[g])
    );
    assign res[g] = 32'(r);
  end

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  // expected {result, c_out, overflow, zero, negative} from plain signed/unsigned arithmetic
  function automatic logic [35:0] model(int w, logic o, logic [31:0] x, logic [31:0] y);
    longint m = longint'(1) << w;
    longint ua = longint'(x) & (m - 1);
    longint ub = longint'(y) & (m - 1);
    longint sa = ua >= m / 2 ? ua - m : ua;
    longint sb = ub >= m / 2 ? ub - m : ub;
    longint r = (o ? ua - ub : ua + ub) & (m - 1);
    longint ss = o ? sa - sb : sa + sb;
    logic c = o ? ua >= ub : ua + ub >= m;
    logic v = ss >= m / 2 || ss < -(m / 2);
    return {32'(r), c, v, r == 0, ((r >> (w - 1)) & 1) == 1};
  endfunction

  function automatic logic [35:0] obs(int g);
    return {res[g], c_v[g], ov_v[g], z_v[g], n_v[g]};
  endfunction

  task automatic do_op(input logic o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] pre[3];
    for (int g = 0; g < 3; g++) begin
      lat[g] = -1;
      pre[g] = res[g];
      early[g] = 0;
    end
    both = 0;
    op = o; a = x; b = y; start = 1;
    @(posedge clock); #1;
    start = 0; op = 1'($urandom); a = $urandom; b = $urandom;
    for (int g = 0; g < 3; g++) busy0[g] = busy_v[g];
    for (int cyc = 0; cyc <= 12 && (lat[0] < 0 || lat[1] < 0 || lat[2] < 0); cyc++) begin
      if (cyc > 0) begin @(posedge clock); #1; end
      for (int g = 0; g < 3; g++) begin
        if (busy_v[g] && done_v[g]) both = 1;
        if (lat[g] < 0) begin
          if (done_v[g]) begin lat[g] = cyc; got[g] = obs(g); end
          else if (res[g] !== pre[g]) early[g] = 1;
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({busy_v[g], done_v[g], obs(g)} !== {2'b00, 32'd0, 4'b0010}) begin
        errors++;
        $display("FAIL reset[%0d]: got busy=%b done=%b res=%h flags=%b, want 0 0 0 0010", g, busy_v[g], done_v[g], res[g], obs(g) & 4'hf);
      end
    end
  endtask

  task automatic test_directed();
    logic [32:0] vec[7] = '{{1'b0, 32'h5}, {1'b0, 32'hFFFF_FFFF}, {1'b0, 32'h7FFF_FFFF}, {1'b1, 32'h3},
                          {1'b0, 32'hFFFF}, {1'b0, 32'h7FFF}, {1'b1, 32'hA}};
    logic [31:0] bv[7] = '{32'h3, 32'h1, 32'h1, 32'h5, 32'h1, 32'h1, 32'hA};
    for (int i = 0; i < 7; i++) begin
      do_op(vec[i][32], vec[i][31:0], bv[i]);
      for (int g = 0; g < 3; g++) begin
        logic [35:0] e = model(wd[g], vec[i][32], vec[i][31:0], bv[i]);
        checks++;
        if (got[g] !== e || lat[g] != nch[g] || !busy0[g] || early[g]) begin
          errors++;
          $display("FAIL directed[%0d] inst%0d: got %h lat=%0d busy0=%b early=%b, want %h lat=%0d", i, g, got[g], lat[g], busy0[g], early[g], e, nch[g]);
        end
      end
      checks++;
      if (both) begin errors++; $display("FAIL directed[%0d] busy_and_done: got 1 want 0", i); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      logic o = 1'($urandom);
      logic [31:0] x = $urandom, y = $urandom;
      if (i % 50 == 0) x = 32'h8000_0000;
      do_op(o, x, y);
      for (int g = 0; g < 3; g++) begin
        logic [35:0] e = model(wd[g], o, x, y);
        checks++;
        if (got[g] !== e || lat[g] != nch[g] || !busy0[g] || early[g] || both) begin
          errors++;
          $display("FAIL random[%0d] inst%0d op=%b a=%h b=%h: got %h lat=%0d both=%b early=%b, want %h lat=%0d", i, g, o, x, y, got[g], lat[g], both, early[g], e, nch[g]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    repeat (6) @(posedge clock); #1;
    op = 1; a = 10; b = 10; start = 1;
    @(posedge clock); #1;
    op = 0; a = 1; b = 2;
    repeat (3) @(posedge clock); #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (busy_v[g] !== 1 || done_v[g] !== 0) begin errors++; $display("FAIL b2b_busy inst%0d: got busy=%b done=%b want 1 0", g, busy_v[g], done_v[g]); end
    end
    @(posedge clock); #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (done_v[g] !== 1 || obs(g) !== model(wd[g], 1, 10, 10)) begin
        errors++;
        $display("FAIL b2b_first inst%0d: got done=%b %h want 1 %h", g, done_v[g], obs(g), model(wd[g], 1, 10, 10));
      end
    end
    @(posedge clock); #1;
    start = 0;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (done_v[g] !== 0 || busy_v[g] !== 1 || res[g] !== 0) begin
        errors++;
        $display("FAIL b2b_restart inst%0d: got done=%b busy=%b res=%h want 0 1 0", g, done_v[g], busy_v[g], res[g]);
      end
    end
    repeat (3) @(posedge clock); #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (done_v[g] !== 0) begin errors++; $display("FAIL b2b_early_done inst%0d: got 1 want 0", g); end
    end
    @(posedge clock); #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (done_v[g] !== 1 || obs(g) !== model(wd[g], 0, 1, 2)) begin
        errors++;
        $display("FAIL b2b_second inst%0d: got done=%b %h want 1 %h", g, done_v[g], obs(g), model(wd[g], 0, 1, 2));
      end
    end
  endtask

  task automatic test_clear_abort();
    int stray = 0;
    repeat (6) @(posedge clock); #1;
    op = 0; a = 32'h1234_5678; b = 32'h1111_1111; start = 1;
    @(posedge clock); #1;
    start = 0;
    @(posedge clock); #1;
    clear = 1;
    #1;
    test_reset();
    start = 1;
    repeat (3) @(posedge clock); #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (busy_v[g] !== 0 || done_v[g] !== 0) begin errors++; $display("FAIL clear_start inst%0d: got busy=%b done=%b want 0 0", g, busy_v[g], done_v[g]); end
    end
    clear = 0; start = 0;
    repeat (6) begin
      @(posedge clock); #1;
      for (int g = 0; g < 3; g++) if (done_v[g] || busy_v[g]) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL clear_no_done: got %0d active cycles want 0", stray); end
    do_op(0, 5, 3);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (got[g] !== model(wd[g], 0, 5, 3) || lat[g] != nch[g]) begin
        errors++;
        $display("FAIL clear_recover inst%0d: got %h lat=%0d want %h lat=%0d", g, got[g], lat[g], model(wd[g], 0, 5, 3), nch[g]);
      end
    end
  endtask

  initial begin
    clear = 1; start = 0; op = 0; a = 0; b = 0;
    #3;
    test_reset();
    #9;
    clear = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_clear_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
